// File: rtl/seg7_scan_capture.sv
// Snoops a 4-digit multiplexed 7-segment bus. Each digit's glyph is decoded back to a hex nibble
// once it has been stable for long enough, and a 16-bit word is published when all four digits are known.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic        glyph_err,
    output logic [1:0]  err_digit
);

    localparam logic [7:0] C_CNT_SAT    = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_CNT_SETTLE = 8'(STABLE_CYCLES - 2);

    // Returns {recognised, nibble}.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   f_decode = 5'h10;
            7'h30:   f_decode = 5'h11;
            7'h6D:   f_decode = 5'h12;
            7'h79:   f_decode = 5'h13;
            7'h33:   f_decode = 5'h14;
            7'h5B:   f_decode = 5'h15;
            7'h5F:   f_decode = 5'h16;
            7'h70:   f_decode = 5'h17;
            7'h7F:   f_decode = 5'h18;
            7'h7B:   f_decode = 5'h19;
            7'h77:   f_decode = 5'h1A;
            7'h1F:   f_decode = 5'h1B;
            7'h4E:   f_decode = 5'h1C;
            7'h3D:   f_decode = 5'h1D;
            7'h4F:   f_decode = 5'h1E;
            7'h47:   f_decode = 5'h1F;
            default: f_decode = 5'h00;
        endcase
    endfunction

    // Returns {exactly_one_low, digit_index}.
    function automatic logic [2:0] f_select(input logic [3:0] an_v);
        case (an_v)
            4'b1110: f_select = 3'b1_00;
            4'b1101: f_select = 3'b1_01;
            4'b1011: f_select = 3'b1_10;
            4'b0111: f_select = 3'b1_11;
            default: f_select = 3'b0_00;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0][10:0] r_sync;
    logic [10:0]                  r_prev;
    logic [7:0]                   r_cnt;
    logic [3:0][3:0]              r_digits;

    logic [10:0]     w_in;
    logic [10:0]     w_sample;
    logic            w_same;
    logic            w_settle;
    logic [2:0]      w_sel;
    logic [4:0]      w_dec;
    logic            w_accept;
    logic            w_bad;
    logic [3:0][3:0] w_digits_nxt;
    logic [3:0]      w_seen_nxt;
    logic            w_complete;

    assign w_in     = {an, a, b, c, d, e, f, g};
    assign w_sample = r_sync[SYNC_STAGES-1];
    assign w_same   = (w_sample == r_prev);
    // Fires only on the transition into STABLE_CYCLES-1; saturation keeps a static display from re-firing.
    assign w_settle = w_same && (r_cnt == C_CNT_SETTLE);

    // Synchronizer chain for all eleven bus bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
        end
    end

    // Stability tracking of the synchronized sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 11'h000;
            r_cnt  <= 8'h00;
        end else begin
            r_prev <= w_sample;
            if (!w_same) begin
                r_cnt <= 8'h00;
            end else if (r_cnt < C_CNT_SAT) begin
                r_cnt <= r_cnt + 8'h01;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Classify a settled sample and compute the next digit/frame state.
    always_comb begin
        w_sel        = f_select(w_sample[10:7]);
        w_dec        = f_decode(w_sample[6:0]);
        w_accept     = 1'b0;
        w_bad        = 1'b0;
        w_digits_nxt = r_digits;
        w_seen_nxt   = digit_seen;
        if (w_settle && w_sel[2]) begin
            if (w_dec[4]) begin
                w_accept = 1'b1;
            end else begin
                w_bad = 1'b1;
            end
        end else begin
            w_accept = 1'b0;
            w_bad    = 1'b0;
        end
        if (w_accept) begin
            w_digits_nxt[w_sel[1:0]] = w_dec[3:0];
            w_seen_nxt[w_sel[1:0]]   = 1'b1;
        end else begin
            w_digits_nxt = r_digits;
            w_seen_nxt   = digit_seen;
        end
        w_complete = w_accept && (w_seen_nxt == 4'b1111);
    end

    // Digit store, frame publication and error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits    <= '0;
            value       <= 16'h0000;
            frame_valid <= 1'b0;
            digit_seen  <= 4'b0000;
            glyph_err   <= 1'b0;
            err_digit   <= 2'b00;
        end else begin
            r_digits    <= w_digits_nxt;
            frame_valid <= w_complete;
            glyph_err   <= w_bad;
            if (w_complete) begin
                value      <= w_digits_nxt;
                digit_seen <= 4'b0000;
            end else begin
                value      <= value;
                digit_seen <= w_seen_nxt;
            end
            if (w_bad) begin
                err_digit <= w_sel[1:0];
            end else begin
                err_digit <= err_digit;
            end
        end
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the team's 7-segment path: the reverse of the hex-to-segment decoder.
- Samples a 4-digit, time-multiplexed 7-segment bus (anode selects plus segments a..g).
- Waits for each digit's pattern to settle, decodes each glyph back to a 4-bit hex value, and presents a complete 16-bit word once all four digits have been captured.
- Used as a loop-back checker and display-snooper next to the display driver.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is accepted (legal range 2..255).
- SYNC_STAGES, 2, flip-flop stages on every input bit (legal range 2..3).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  4  anode selects, active-low; an[k]=0 selects digit k (digit 0 = least significant nibble).
- a  input  1  segment a, active-high.
- b  input  1  segment b, active-high.
- c  input  1  segment c, active-high.
- d  input  1  segment d, active-high.
- e  input  1  segment e, active-high.
- f  input  1  segment f, active-high.
- g  input  1  segment g, active-high.
- value  output  16  last completed frame: {digit3, digit2, digit1, digit0}.
- frame_valid  output  1  one-cycle pulse when value updates.
- digit_seen  output  4  per-digit captured flags for the frame in progress.
- glyph_err  output  1  one-cycle pulse on a settled, selected, unrecognised pattern.
- err_digit  output  2  index of the digit that caused the last glyph_err; holds until the next error.

Behaviour:
- Reset (asynchronous, active-high): value=16'h0000, frame_valid=0, digit_seen=4'b0000, glyph_err=0, err_digit=0. Synchronizers, stability counter and digit registers are also cleared. Reset asserted mid-frame discards all partial digits.
- Input synchronization: all 11 input bits pass through SYNC_STAGES flops. The sample is the 11-bit vector {an_s, seg_s}, with seg_s = {a,b,c,d,e,f,g} and a as MSB.
- Stability counter cnt:
  - If the sample equals the previous cycle's sample, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt=0.
  - A "settle" event fires on exactly one cycle: the cycle cnt reaches STABLE_CYCLES-1, i.e. when STABLE_CYCLES identical samples have been seen. No further settle occurs until the sample changes.
- On settle, if an_s is not exactly one-low (1111, or two or more bits low), the event is ignored: no state change and no error.
- Glyph table, seg_s hex to nibble:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F
- Settle on a one-low an_s selecting digit k:
  - Glyph in table: digit_reg[k] <= nibble and digit_seen[k] <= 1. A re-captured digit is overwritten with the newest value.
  - Glyph not in table (including blank 00): glyph_err pulses on the next cycle and err_digit <= k. digit_seen[k] is unchanged.
- Frame completion:
  - On the clock edge where digit_seen becomes (or already is) 4'b1111 after an accepted digit, the next cycle shows value = {digit_reg[3..0]}, frame_valid=1 for one cycle, and digit_seen=0.
  - Latency from the accepting settle cycle to frame_valid is 1 cycle.
- Captured digits may arrive in any order.
- Simultaneous events: the completing write is included in value.
- The counter is 8 bits wide. Saturation prevents wrap on a static display, so a static display produces one settle, not a periodic one.
- Design intent: purely synchronous logic apart from the reset, with no combinational path from input to output.

Test Plan:
- Scan sequence: an=1110/seg 30, then 1101/6D, then 1011/79, then 0111/33, each held 10 cycles → one frame_valid pulse, value=16'h4321, digit_seen returns to 0000.
- Glitch: on digit 0, drive 7F for 2 cycles, then 4E held 10 cycles (STABLE_CYCLES=4) → digit_reg[0]=C only; the 7F glitch is never captured; after the remaining digits are supplied with 7E, value=16'h000C.
- Bad glyph: digit 2 held at 00 → glyph_err pulse 1 cycle, err_digit=2, digit_seen[2]=0, no frame_valid until digit 2 is resent as a valid glyph.
- Non-one-hot select: an=1100 or an=1111 held 20 cycles with seg 7F → no glyph_err, digit_seen unchanged.
- Reset mid-frame: capture digits 0 and 1, assert rst for 1 cycle asynchronously → digit_seen=0000, value=0000; frame_valid occurs only after all four digits are recaptured.
- Static display: an=1110/30 held 1000 cycles → exactly one accept (digit_seen[0] set once), no counter wrap, no repeated events.
